// File: rtl/bp_fe_cmd_responder.sv
// FE endpoint of the BE/FE command/queue protocol: owns the fetch PC, drops stale fetches, buffers fe_queue entries.
// Optional: `define BP_FE_MISALIGN_EXC_EN turns misaligned command targets into a single exception entry.
module bp_fe_cmd_responder #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int buffer_els_p  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     fe_cmd_v_i,
  input  logic [1:0]               fe_cmd_opcode_i,
  input  logic [vaddr_width_p-1:0] fe_cmd_npc_i,
  output logic                     fe_cmd_yumi_o,
  output logic                     fetch_v_o,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  input  logic                     fetch_ready_and_i,
  input  logic                     fetch_resp_v_i,
  input  logic [instr_width_p-1:0] fetch_resp_instr_i,
  output logic                     fe_queue_v_o,
  output logic                     fe_queue_msg_type_o,
  output logic [vaddr_width_p-1:0] fe_queue_pc_o,
  output logic [instr_width_p-1:0] fe_queue_instr_o,
  input  logic                     fe_queue_ready_and_i
);
  localparam int ptr_w_lp = $clog2(buffer_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_wait = 2'd2;

  localparam logic [1:0] op_state_reset = 2'd0;
  localparam logic [1:0] op_wait        = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [cnt_w_lp-1:0]      out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [ptr_w_lp-1:0]      wp_q, wp_d, rp_q, rp_d, pcf_wp_q, pcf_rp_q;
  logic [vaddr_width_p-1:0] pcf_mem_q   [buffer_els_p];
  logic [vaddr_width_p-1:0] buf_pc_q    [buffer_els_p];
  logic [instr_width_p-1:0] buf_instr_q [buffer_els_p];

  logic                     flush, exc, fire, resp_ok, enq, deq;
  logic [vaddr_width_p-1:0] npc_ld;
  logic [cnt_w_lp:0]        credit_used;

  assign fe_cmd_yumi_o = fe_cmd_v_i;

  // IDLE only wakes on state_reset; every other non-wait opcode (incl. reserved) redirects.
  assign flush = fe_cmd_v_i & (fe_cmd_opcode_i != op_wait)
               & ((state_q != st_idle) | (fe_cmd_opcode_i == op_state_reset));

`ifdef BP_FE_MISALIGN_EXC_EN
  assign exc    = flush & (fe_cmd_npc_i[1:0] != 2'b00);
  assign npc_ld = fe_cmd_npc_i;
`else
  assign exc    = 1'b0;
  assign npc_ld = fe_cmd_npc_i & ~vaddr_width_p'(3);
`endif

  // Credit covers in-flight fetches and buffered entries, so a response always has a slot.
  assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign fetch_v_o   = (state_q == st_run) & ~fe_cmd_v_i
                     & (credit_used < {1'b0, cnt_w_lp'(buffer_els_p)});
  assign fetch_pc_o  = pc_q;

  assign fire    = fetch_v_o & fetch_ready_and_i;
  assign resp_ok = fetch_resp_v_i & (out_q != '0);
  assign enq     = resp_ok & (drop_q == '0) & ~flush;
  assign deq     = fe_queue_v_o & fe_queue_ready_and_i;

  assign fe_queue_v_o     = (cnt_q != '0);
  assign fe_queue_pc_o    = buf_pc_q[rp_q];
  assign fe_queue_instr_o = buf_instr_q[rp_q];

  always_comb begin
    state_d = state_q;
    pc_d    = fire ? pc_q + vaddr_width_p'(4) : pc_q;
    if (flush) begin
      pc_d    = npc_ld;
      state_d = exc ? st_wait : st_run;
    end else if (fe_cmd_v_i && fe_cmd_opcode_i == op_wait && state_q == st_run) begin
      state_d = st_wait;
    end
  end

  always_comb begin
    out_d  = out_q + cnt_w_lp'(fire) - cnt_w_lp'(resp_ok);
    drop_d = drop_q - cnt_w_lp'(resp_ok & (drop_q != '0));
    wp_d   = wp_q + ptr_w_lp'(enq);
    rp_d   = rp_q + ptr_w_lp'(deq);
    cnt_d  = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    if (flush) begin
      // Everything still in flight belongs to the old stream.
      drop_d = out_d;
      wp_d   = ptr_w_lp'(exc);
      rp_d   = '0;
      cnt_d  = cnt_w_lp'(exc);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= st_idle;
      pc_q     <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      pcf_wp_q <= '0;
      pcf_rp_q <= '0;
      for (int i = 0; i < buffer_els_p; i++) begin
        pcf_mem_q[i]   <= '0;
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      // PC FIFO pops on every response, dropped or not, so it stays aligned with the source.
      if (fire) begin
        pcf_mem_q[pcf_wp_q] <= pc_q;
        pcf_wp_q            <= pcf_wp_q + ptr_w_lp'(1);
      end
      if (resp_ok) pcf_rp_q <= pcf_rp_q + ptr_w_lp'(1);
      if (exc) begin
        buf_pc_q[0]    <= fe_cmd_npc_i;
        buf_instr_q[0] <= '0;
      end else if (enq) begin
        buf_pc_q[wp_q]    <= pcf_mem_q[pcf_rp_q];
        buf_instr_q[wp_q] <= fetch_resp_instr_i;
      end
    end
  end

`ifdef BP_FE_MISALIGN_EXC_EN
  logic [buffer_els_p-1:0] buf_exc_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   buf_exc_q       <= '0;
    else if (exc)     buf_exc_q[0]    <= 1'b1;
    else if (enq)     buf_exc_q[wp_q] <= 1'b0;
  end
  assign fe_queue_msg_type_o = buf_exc_q[rp_q];
`else
  assign fe_queue_msg_type_o = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq && !deq && cnt_q == cnt_w_lp'(buffer_els_p)));
  a_resp_expected: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fetch_resp_v_i && out_q == '0 && state_q != st_idle));

endmodule

// File: tb/tb_bp_fe_cmd_responder.sv
// Directed bench for bp_fe_cmd_responder: queue-level reference model checked every cycle, plus literal pins.
module tb_bp_fe_cmd_responder;
  localparam int VW  = 39;
  localparam int IW  = 32;
  localparam int ELS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_v = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [VW-1:0] cmd_npc = '0;
  logic          yumi;
  logic          fetch_v;
  logic [VW-1:0] fetch_pc;
  logic          src_rdy = 1'b1;
  logic          resp_v = 1'b0;
  logic [IW-1:0] resp_instr = '0;
  logic          q_v, q_type;
  logic [VW-1:0] q_pc;
  logic [IW-1:0] q_instr;
  logic          be_rdy = 1'b1;

  always #5 clk = ~clk;

  bp_fe_cmd_responder #(.vaddr_width_p(VW), .instr_width_p(IW), .buffer_els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .fe_cmd_v_i(cmd_v), .fe_cmd_opcode_i(cmd_op), .fe_cmd_npc_i(cmd_npc), .fe_cmd_yumi_o(yumi),
    .fetch_v_o(fetch_v), .fetch_pc_o(fetch_pc), .fetch_ready_and_i(src_rdy),
    .fetch_resp_v_i(resp_v), .fetch_resp_instr_i(resp_instr),
    .fe_queue_v_o(q_v), .fe_queue_msg_type_o(q_type), .fe_queue_pc_o(q_pc),
    .fe_queue_instr_o(q_instr), .fe_queue_ready_and_i(be_rdy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct { logic [VW-1:0] pc; int due; } src_t;
  typedef struct { logic [VW-1:0] pc; bit stale; } infl_t;
  typedef struct { logic [VW-1:0] pc; bit exc; } ent_t;

  src_t          src_q[$];
  infl_t         m_infl[$];
  ent_t          m_buf[$];
  int            m_state = 0;  // 0 idle, 1 run, 2 wait
  logic [VW-1:0] m_pc = '0;
  logic [VW-1:0] fetch_log[$];
  logic [VW-1:0] deq_log[$];

  function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
    return pc[IW-1:0] ^ 32'h5A5A_0013;
  endfunction

  // Missing entries read as all-ones, which no aligned PC can equal.
  function automatic logic [VW-1:0] at(input logic [VW-1:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  function automatic bit m_fetch_v();
    return (m_state == 1) && !cmd_v && (m_infl.size() + m_buf.size() < ELS);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    if (!rst_n) begin
      chk("rst_yumi",     64'(yumi),     64'd0);
      chk("rst_fetch_v",  64'(fetch_v),  64'd0);
      chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
      chk("rst_q_v",      64'(q_v),      64'd0);
      chk("rst_q_type",   64'(q_type),   64'd0);
      chk("rst_q_pc",     64'(q_pc),     64'd0);
      chk("rst_q_instr",  64'(q_instr),  64'd0);
      return;
    end
    chk("yumi",     64'(yumi),     64'(cmd_v));
    chk("fetch_v",  64'(fetch_v),  64'(m_fetch_v()));
    chk("fetch_pc", 64'(fetch_pc), 64'(m_pc));
    chk("q_v",      64'(q_v),      64'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("q_pc",    64'(q_pc),    64'(m_buf[0].pc));
      chk("q_type",  64'(q_type),  64'(m_buf[0].exc));
      chk("q_instr", 64'(q_instr), m_buf[0].exc ? 64'd0 : 64'(instr_of(m_buf[0].pc)));
    end
  endtask

  task automatic model_step();
    bit fire, resp, flush, exc;
    infl_t f;
    if (!rst_n) begin
      m_state = 0; m_pc = '0;
      m_infl.delete(); m_buf.delete();
      return;
    end
    fire  = m_fetch_v() && src_rdy;
    resp  = resp_v && (m_infl.size() > 0);
    flush = cmd_v && (cmd_op != 2'd2) && (m_state != 0 || cmd_op == 2'd0);
    exc   = 1'b0;
`ifdef BP_FE_MISALIGN_EXC_EN
    exc   = flush && (cmd_npc[1:0] != 2'b00);
`endif
    if (m_buf.size() > 0 && be_rdy) void'(m_buf.pop_front());
    if (resp) begin
      f = m_infl.pop_front();
      if (!f.stale && !flush) m_buf.push_back('{pc: f.pc, exc: 1'b0});
    end
    if (fire) begin
      m_infl.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + VW'(4);
    end
    if (flush) begin
      m_buf.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      if (exc) begin
        m_buf.push_back('{pc: cmd_npc, exc: 1'b1});
        m_pc = cmd_npc;
        m_state = 2;
      end else begin
        m_pc = {cmd_npc[VW-1:2], 2'b00};
        m_state = 1;
      end
    end else if (cmd_v && cmd_op == 2'd2 && m_state == 1) begin
      m_state = 2;
    end
  endtask

  // One clock cycle: drive just after negedge, check, advance the model and the source.
  task automatic step(input bit cv = 1'b0, input logic [1:0] op = 2'd0, input logic [VW-1:0] npc = '0);
    if (!rst_n) src_q.delete();
    cmd_v = cv; cmd_op = op; cmd_npc = npc;
    resp_v = (src_q.size() > 0) && (src_q[0].due <= cyc);
    resp_instr = resp_v ? instr_of(src_q[0].pc) : '0;
    #1;
    compare();
    if (rst_n) begin
      if (fetch_v && src_rdy) begin
        src_q.push_back('{pc: fetch_pc, due: cyc + lat});
        fetch_log.push_back(fetch_pc);
      end
      if (resp_v) void'(src_q.pop_front());
      if (q_v && be_rdy) deq_log.push_back(q_pc);
    end
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    step();

    // Redirect in IDLE is consumed but ignored.
    fetch_log.delete();
    step(1'b1, 2'd1, 39'h5000); step(); step();
    chk("idle_nofetch", 64'(fetch_log.size()), 64'd0);

    // Streaming start at 0x8000_0000, one entry per cycle.
    fetch_log.delete(); deq_log.delete();
    step(1'b1, 2'd0, 39'h8000_0000);
    repeat (12) step();
    chk("t1_deq0", 64'(at(deq_log, 0)), 64'h8000_0000);
    chk("t1_deq1", 64'(at(deq_log, 1)), 64'h8000_0004);
    chk("t1_deq2", 64'(at(deq_log, 2)), 64'h8000_0008);

    // BE stalled: credit caps new fetches at the buffer depth.
    be_rdy = 1'b0;
    fetch_log.delete(); deq_log.delete();
    step(1'b1, 2'd1, 39'h4000);
    repeat (10) step();
    chk("t2_nfetch", 64'(fetch_log.size()), 64'd4);
    chk("t2_stalled_fv", 64'(fetch_v), 64'd0);
    be_rdy = 1'b1;
    repeat (8) step();
    chk("t2_deq0", 64'(at(deq_log, 0)), 64'h4000);
    chk("t2_deq3", 64'(at(deq_log, 3)), 64'h400C);
    chk("t2_deq4", 64'(at(deq_log, 4)), 64'h4010);

    // Latency 3: drain in WAIT, restart, redirect with three fetches outstanding.
    lat = 3;
    step(1'b1, 2'd2, '0);
    repeat (6) step();
    fetch_log.delete();
    step(1'b1, 2'd1, 39'h3000);
    repeat (3) step();
    chk("t3_outstanding", 64'(fetch_log.size()), 64'd3);
    deq_log.delete();
    step(1'b1, 2'd1, 39'h1000);
    chk("t3_q_empty", 64'(q_v), 64'd0);
    step();
    repeat (8) step();
    chk("t3_deq0", 64'(at(deq_log, 0)), 64'h1000);
    chk("t3_deq1", 64'(at(deq_log, 1)), 64'h1004);

    // Wait: no fetching for 20 cycles, then redirect resumes next cycle.
    fetch_log.delete();
    step(1'b1, 2'd2, '0);
    repeat (20) step();
    chk("t4_nofetch", 64'(fetch_log.size()), 64'd0);
    step(1'b1, 2'd1, 39'h2000);
    step();
    chk("t4_resume", 64'(at(fetch_log, 0)), 64'h2000);

    // PC wrap at the top of the address space.
    repeat (4) step();
    fetch_log.delete();
    step(1'b1, 2'd1, 39'h7F_FFFF_FFFC);
    repeat (8) step();
    chk("t5_top", 64'(at(fetch_log, 0)), 64'h7F_FFFF_FFFC);
    chk("t5_wrap", 64'(at(fetch_log, 1)), 64'h0);

    // Misaligned state_reset target.
    fetch_log.delete(); deq_log.delete();
    step(1'b1, 2'd0, 39'h1002);
    repeat (10) step();
`ifdef BP_FE_MISALIGN_EXC_EN
    chk("t6_nofetch", 64'(fetch_log.size()), 64'd0);
    chk("t6_exc_pc", 64'(at(deq_log, 0)), 64'h1002);
`else
    chk("t6_fetch0", 64'(at(fetch_log, 0)), 64'h1000);
    chk("t6_fetch1", 64'(at(fetch_log, 1)), 64'h1004);
`endif

    // Reset mid-stream clears everything at once.
    step(1'b1, 2'd0, 39'h8000_0000);
    repeat (4) step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t7_q_v_after_rst", 64'(q_v), 64'd0);
    fetch_log.delete();
    step(1'b1, 2'd0, 39'h100);
    repeat (6) step();
    chk("t7_restart", 64'(at(fetch_log, 0)), 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
